lfsr_sched: RTL and testbench

Round-robin scheduler that shares one 32-bit Fibonacci LFSR among NREQ requesters and sequences its seeding and warm-up. Each granted request consumes exactly one LFSR word and advances the register by one step; the LFSR never advances while idle, so the output sequence is deterministic for a given seed and request pattern. Sits between the pseudo-random datapath and its consumers (test-pattern generators, randomized arbiters).

---
 rtl/lfsr_sched.sv | 105 ++++++++++
 tb/tb_lfsr_sched.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_sched.sv
// Round-robin scheduler sharing one 32-bit Fibonacci LFSR among NREQ requesters; seeding and warm-up sequencing.
// Latency: grant/rand_data one cycle after req is sampled in SERVE; backpressure: requests wait while busy or reseeding.
module lfsr_sched #(
  parameter int          NREQ       = 4,
  parameter int          WARMUP     = 8,
  parameter logic [31:0] RESET_SEED = 32'h0000_0001
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            seed_valid,
  input  logic [31:0]     seed,
  output logic            seed_ready,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic            rand_valid,
  output logic [31:0]     rand_data,
  output logic            busy
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(WARMUP + 2);

  typedef enum logic {ST_WARMUP, ST_SERVE} state_t;

  state_t          state;
  logic [31:0]     lfsr;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   sel;
  logic            found;
  logic [31:0]     lfsr_nxt;

  assign lfsr_nxt = {lfsr[30:0], lfsr[7] ^ lfsr[16] ^ lfsr[19] ^ lfsr[25] ^ lfsr[29]};

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    int k;
    k     = 0;
    sel   = ptr;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      k = (int'(ptr) + i) % NREQ;
      if (!found && req[k]) begin
        found = 1'b1;
        sel   = PW'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_WARMUP;
      lfsr       <= RESET_SEED;
      cnt        <= '0;
      ptr        <= PW'(NREQ - 1);
      grant      <= '0;
      rand_valid <= 1'b0;
      rand_data  <= '0;
      seed_ready <= 1'b0;
      busy       <= 1'b1;
    end else begin
      grant      <= '0;
      rand_valid <= 1'b0;
      case (state)
        ST_WARMUP: begin
          if (WARMUP == 0) begin
            state      <= ST_SERVE;
            busy       <= 1'b0;
            seed_ready <= 1'b1;
          end else begin
            lfsr <= lfsr_nxt;
            if (int'(cnt) == WARMUP - 1) begin
              cnt        <= '0;
              state      <= ST_SERVE;
              busy       <= 1'b0;
              seed_ready <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_SERVE: begin
          if (seed_valid) begin
            // An all-zero seed would lock the LFSR, so the reset seed stands in.
            lfsr <= (seed == 32'd0) ? RESET_SEED : seed;
            cnt  <= '0;
            if (WARMUP != 0) begin
              state      <= ST_WARMUP;
              busy       <= 1'b1;
              seed_ready <= 1'b0;
            end
          end else if (found) begin
            grant      <= NREQ'(1) << sel;
            rand_valid <= 1'b1;
            rand_data  <= lfsr;
            lfsr       <= lfsr_nxt;
            ptr        <= sel;
          end
        end
        default: state <= ST_WARMUP;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_sched.sv
// Directed and random checks of lfsr_sched against a cycle-level reference model of the scheduling rules.
module tb_lfsr_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        seed_valid, seed_valid1;
  logic [31:0] seed, seed1;
  logic [3:0]  req, req1;
  logic        seed_ready, seed_ready1;
  logic [3:0]  grant, grant1;
  logic        rand_valid, rand_valid1;
  logic [31:0] rand_data, rand_data1;
  logic        busy, busy1;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  lfsr_sched #(.NREQ(4), .WARMUP(8), .RESET_SEED(32'h0000_0001)) dut (
    .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed(seed), .seed_ready(seed_ready),
    .req(req), .grant(grant), .rand_valid(rand_valid), .rand_data(rand_data), .busy(busy)
  );

  lfsr_sched #(.NREQ(4), .WARMUP(0), .RESET_SEED(32'h0000_0001)) dut0 (
    .clk(clk), .rst(rst), .seed_valid(seed_valid1), .seed(seed1), .seed_ready(seed_ready1),
    .req(req1), .grant(grant1), .rand_valid(rand_valid1), .rand_data(rand_data1), .busy(busy1)
  );

  // Reference model state for the WARMUP=8 instance
  logic [31:0] m_lfsr, m_data;
  logic [3:0]  m_grant;
  logic        m_valid, m_serve;
  int          m_ptr, m_left;

  function automatic logic [31:0] ref_step(input logic [31:0] x);
    logic [31:0] t;
    t = (x >> 7) ^ (x >> 16) ^ (x >> 19) ^ (x >> 25) ^ (x >> 29);
    return (x << 1) | (t & 32'd1);
  endfunction

  task automatic m_reset();
    m_lfsr  = 32'd1;
    m_data  = 32'd0;
    m_grant = 4'd0;
    m_valid = 1'b0;
    m_serve = 1'b0;
    m_ptr   = 3;
    m_left  = 8;
  endtask

  task automatic m_tick();
    m_grant = 4'd0;
    m_valid = 1'b0;
    if (!m_serve) begin
      if (m_left > 0) begin
        m_lfsr = ref_step(m_lfsr);
        m_left--;
      end
      if (m_left == 0) m_serve = 1'b1;
    end else if (seed_valid) begin
      m_lfsr  = (seed == 32'd0) ? 32'd1 : seed;
      m_serve = 1'b0;
      m_left  = 8;
    end else if (req != 4'd0) begin
      for (int i = 1; i <= 4; i++) begin
        int k;
        k = (m_ptr + i) % 4;
        if (req[k]) begin
          m_grant = 4'd1 << k;
          m_ptr   = k;
          break;
        end
      end
      m_valid = 1'b1;
      m_data  = m_lfsr;
      m_lfsr  = ref_step(m_lfsr);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock: model consumes the inputs seen at this edge, outputs compared mid-cycle.
  task automatic step();
    m_tick();
    @(negedge clk);
    chk("grant", 32'(grant), 32'(m_grant));
    chk("rand_valid", 32'(rand_valid), 32'(m_valid));
    chk("rand_data", rand_data, m_data);
    chk("busy", 32'(busy), 32'(!m_serve));
    chk("seed_ready", 32'(seed_ready), 32'(m_serve));
  endtask

  initial begin
    logic [3:0] eg;
    rst = 1'b0;
    seed_valid = 1'b0; seed = 32'd0; req = 4'd0;
    seed_valid1 = 1'b0; seed1 = 32'd0; req1 = 4'd0;
    m_reset();
    repeat (2) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_valid", 32'(rand_valid), 32'd0);
    chk("rst_data", rand_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_seed_ready", 32'(seed_ready), 32'd0);
    chk("rst_busy_w0", 32'(busy1), 32'd1);

    // Power-up warm-up with req[0] held from the start
    rst = 1'b1;
    req = 4'b0001;
    chk("warm_busy0", 32'(busy), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i < 8) chk("warm_busy", 32'(busy), 32'd1);
    end
    chk("warm_done", 32'(busy), 32'd0);
    step();
    chk("first_grant", 32'(grant), 32'd1);
    chk("first_word", rand_data, 32'h0000_0101);
    step();
    chk("second_word", rand_data, 32'h0000_0202);

    // Reset in the middle of back-to-back grants
    req = 4'b1111;
    step();
    step();
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_grant", 32'(grant), 32'd0);
    chk("arst_valid", 32'(rand_valid), 32'd0);
    chk("arst_data", rand_data, 32'd0);
    chk("arst_busy", 32'(busy), 32'd1);
    m_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (8) step();
    for (int i = 0; i < 5; i++) begin
      step();
      eg = 4'b0001 << (i % 4);
      chk("rr_grant", 32'(grant), 32'(eg));
      chk("rr_word", rand_data, 32'h0000_0101 << i);
    end

    // Idle: LFSR must hold
    req = 4'b0000;
    repeat (20) step();
    req = 4'b0100;
    step();
    chk("idle_grant", 32'(grant), 32'b0100);
    chk("idle_word", rand_data, 32'h0000_2020);
    req = 4'b0000;

    // Zero seed with a simultaneous request
    seed_valid = 1'b1; seed = 32'd0; req = 4'b0001;
    step();
    chk("reseed_nogrant", 32'(grant), 32'd0);
    chk("reseed_busy", 32'(busy), 32'd1);
    seed_valid = 1'b0;
    repeat (7) step();
    chk("reseed_still_busy", 32'(busy), 32'd1);
    step();
    chk("reseed_ready", 32'(busy), 32'd0);
    step();
    chk("reseed_grant", 32'(grant), 32'd1);
    chk("reseed_word", rand_data, 32'h0000_0101);

    // Random traffic with occasional reseeds
    for (int n = 0; n < 400; n++) begin
      req        = 4'($urandom_range(0, 15));
      seed_valid = ($urandom_range(0, 15) == 0);
      seed       = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      step();
    end
    seed_valid = 1'b0;
    req = 4'd0;

    // WARMUP=0 instance: reseed with no busy window
    seed_valid1 = 1'b1; seed1 = 32'h0000_0080;
    step();
    chk("w0_busy", 32'(busy1), 32'd0);
    chk("w0_seed_ready", 32'(seed_ready1), 32'd1);
    chk("w0_nogrant", 32'(grant1), 32'd0);
    seed_valid1 = 1'b0; req1 = 4'b0001;
    step();
    chk("w0_grant", 32'(grant1), 32'd1);
    chk("w0_valid", 32'(rand_valid1), 32'd1);
    chk("w0_word", rand_data1, 32'h0000_0080);
    step();
    chk("w0_word2", rand_data1, 32'h0000_0101);
    req1 = 4'd0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
